// File: rtl/pcpu_pkg.sv
// Shared definitions for the pipelined CPU: data width, next-PC op encodings
// and the bubble instruction word.
package pcpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npcop_e;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4 or a control-transfer target driven by
// the instruction currently in EX.
module pc_next
  import pcpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      npcop,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_alu,
  output logic [XLEN-1:0] npc,
  output logic            redirect,
  output logic            err
);

  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    npc      = pc_plus4;
    redirect = 1'b0;
    err      = 1'b0;
    case (npcop)
      NPC_PLUS4: begin
        npc = pc_plus4;
      end
      NPC_BRANCH, NPC_JUMP: begin
        npc      = ex_pc + ex_imm;
        redirect = 1'b1;
      end
      NPC_JALR: begin
        npc      = ex_alu & ~32'h1;
        redirect = 1'b1;
      end
      default: begin
        // Unknown encodings fall back to sequential fetch but are flagged.
        npc = pc_plus4;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register feeding decode.
module if_stage
  import pcpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_WORD  = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [2:0]      ex_npcop_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_alu_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_ins_o,
  output logic            if_id_vld_o,
  output logic            redirect_o,
  output logic            npc_err_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc;
  logic            redirect;
  logic            npc_err;
  logic [XLEN-1:0] if_id_pc_q;
  logic [XLEN-1:0] if_id_ins_q;
  logic            if_id_vld_q;

  pc_next u_pc_next (
    .pc       (pc_q),
    .npcop    (ex_npcop_i),
    .ex_pc    (ex_pc_i),
    .ex_imm   (ex_imm_i),
    .ex_alu   (ex_alu_i),
    .npc      (npc),
    .redirect (redirect),
    .err      (npc_err)
  );

  // A taken transfer beats stall and flush; a stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      if_id_pc_q  <= '0;
      if_id_ins_q <= NOP_WORD;
      if_id_vld_q <= 1'b0;
    end else if (redirect) begin
      pc_q        <= npc;
      if_id_pc_q  <= pc_q;
      if_id_ins_q <= NOP_WORD;
      if_id_vld_q <= 1'b0;
    end else if (!stall_i) begin
      pc_q       <= npc;
      if_id_pc_q <= pc_q;
      if (flush_i) begin
        if_id_ins_q <= NOP_WORD;
        if_id_vld_q <= 1'b0;
      end else begin
        if_id_ins_q <= imem_data_i;
        if_id_vld_q <= 1'b1;
      end
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign if_id_pc_o  = if_id_pc_q;
  assign if_id_ins_o = if_id_ins_q;
  assign if_id_vld_o = if_id_vld_q;
  assign redirect_o  = redirect;
  assign npc_err_o   = npc_err;

endmodule
